// File: rtl/menu_lcd_pkg.sv
// Shared constants and types for the menu/LCD controller: lcd_bus field layout,
// DDRAM row addresses, menu mode and frame streamer state encodings.
package menu_lcd_pkg;

   localparam int         LCD_RS_BIT = 9;
   localparam int         LCD_RW_BIT = 8;
   localparam logic [7:0] SET_DDRAM  = 8'h80;

   // HD44780-style DDRAM start address of each display row
   localparam logic [7:0] DDRAM_ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

   typedef enum logic {
      MODE_MENU,
      MODE_ACTIVE
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ADDR,
      ST_CHAR,
      ST_WAIT_ACK,
      ST_WAIT_DONE
   } strm_state_e;

   function automatic logic [9:0] lcd_word(input logic rs, input logic [7:0] data);
      logic [9:0] w;
      w             = '0;
      w[LCD_RS_BIT] = rs;
      w[LCD_RW_BIT] = 1'b0;
      w[7:0]        = data;
      return w;
   endfunction

endpackage

// File: rtl/menu_lcd_ctrl_if.sv
// Word handshake towards lcd_controller: one-cycle enable strobe, 10-bit word,
// busy returned by the display side.
interface menu_lcd_ctrl_if;

   logic       lcd_enable;
   logic [9:0] lcd_bus;
   logic       lcd_busy;

   modport master (
      output lcd_enable,
      output lcd_bus,
      input  lcd_busy
   );

   modport slave (
      input  lcd_enable,
      input  lcd_bus,
      output lcd_busy
   );

endinterface

// File: rtl/lcd_frame_streamer.sv
// Streams a ROWS x COLS character frame to the LCD as address/character words,
// redrawing on screen change, frame content change or refresh timeout.
module lcd_frame_streamer
   import menu_lcd_pkg::*;
#(
   parameter int ROWS           = 2,
   parameter int COLS           = 16,
   parameter int REFRESH_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             screen_id,
   input  logic [ROWS*COLS*8-1:0] frame_data,
   output logic                   frame_busy,
   menu_lcd_ctrl_if.master        lcd
);

   localparam int FW = ROWS * COLS * 8;
   localparam int OW = $clog2(FW);
   localparam int CW = $clog2(COLS);
   localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_RELOAD = (REFRESH_CYCLES > 1) ? TW'(REFRESH_CYCLES - 1) : '0;

   strm_state_e   state_q, state_d;
   logic [1:0]    row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          char_phase_q, char_phase_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    sid_prev_q, sid_prev_d;
   logic [FW-1:0] shadow_q, shadow_d;
   logic          enable_q, enable_d;
   logic [9:0]    bus_q, bus_d;
   logic          frame_busy_q, frame_busy_d;

   logic          trig;
   logic          sid_change;
   logic          data_change;
   logic          timer_exp;
   int            pos;
   logic [OW-1:0] char_off;
   logic [7:0]    cur_char;

   always_comb begin
      pos      = int'(row_q) * COLS + int'(col_q);
      char_off = OW'((ROWS * COLS - 1 - pos) * 8);
      cur_char = shadow_q[char_off +: 8];

      sid_change  = (screen_id != sid_prev_q);
      // LOAD is overwriting the shadow this cycle, so a mismatch there is not new content
      data_change = (state_q != ST_LOAD) && (frame_data != shadow_q);
      timer_exp   = (REFRESH_CYCLES != 0) && (state_q == ST_IDLE) && (timer_q == '0);
      trig        = sid_change | data_change | timer_exp;

      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      char_phase_d = char_phase_q;
      pending_d    = pending_q | trig;
      timer_d      = timer_q;
      sid_prev_d   = screen_id;
      shadow_d     = shadow_q;
      enable_d     = 1'b0;
      bus_d        = bus_q;

      case (state_q)
         ST_IDLE: begin
            if (timer_q != '0) timer_d = timer_q - 1'b1;
            if (pending_q | trig) begin
               state_d   = ST_LOAD;
               pending_d = 1'b0;
            end
         end
         ST_LOAD: begin
            shadow_d = frame_data;
            row_d    = '0;
            col_d    = '0;
            timer_d  = TIMER_RELOAD;
            state_d  = ST_ADDR;
         end
         ST_ADDR: begin
            if (!lcd.lcd_busy) begin
               enable_d     = 1'b1;
               bus_d        = lcd_word(1'b0, SET_DDRAM | DDRAM_ROW_BASE[row_q]);
               char_phase_d = 1'b0;
               state_d      = ST_WAIT_ACK;
            end
         end
         ST_CHAR: begin
            if (!lcd.lcd_busy) begin
               enable_d     = 1'b1;
               bus_d        = lcd_word(1'b1, cur_char);
               char_phase_d = 1'b1;
               state_d      = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (lcd.lcd_busy) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!lcd.lcd_busy) begin
               if (!char_phase_q) begin
                  col_d   = '0;
                  state_d = ST_CHAR;
               end else if (col_q == CW'(COLS - 1)) begin
                  if (row_q == 2'(ROWS - 1)) begin
                     state_d = ST_IDLE;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = ST_ADDR;
                  end
               end else begin
                  col_d   = col_q + 1'b1;
                  state_d = ST_CHAR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      frame_busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
      if (rst) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         char_phase_q <= 1'b0;
         pending_q    <= 1'b1;
         timer_q      <= TIMER_RELOAD;
         sid_prev_q   <= '0;
         enable_q     <= 1'b0;
         bus_q        <= '0;
         frame_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         char_phase_q <= char_phase_d;
         pending_q    <= pending_d;
         timer_q      <= timer_d;
         sid_prev_q   <= sid_prev_d;
         enable_q     <= enable_d;
         bus_q        <= bus_d;
         frame_busy_q <= frame_busy_d;
      end
   end

   assign lcd.lcd_enable = enable_q;
   assign lcd.lcd_bus    = bus_q;
   assign frame_busy     = frame_busy_q;

endmodule

// File: rtl/menu_lcd_ctrl.sv
// Menu navigation (cursor, active item, lockable items) driven by three keys,
// feeding screen_id to the frame streamer that owns the LCD handshake.
module menu_lcd_ctrl
   import menu_lcd_pkg::*;
#(
   parameter int         N_ITEMS        = 4,
   parameter int         ROWS           = 2,
   parameter int         COLS           = 16,
   parameter logic [7:0] LOCK_MASK      = 8'b0000_0100,
   parameter int         REFRESH_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_next,
   input  logic                   key_sel,
   input  logic                   key_back,
   input  logic                   item_done,
   input  logic [ROWS*COLS*8-1:0] frame_data,
   menu_lcd_ctrl_if.master        lcd,
   output logic [3:0]             screen_id,
   output logic [N_ITEMS-1:0]     item_active,
   output logic                   frame_busy
);

   localparam int K_NEXT = 0;
   localparam int K_SEL  = 1;
   localparam int K_BACK = 2;

   logic [2:0]         key_q, key_d;
   logic [2:0]         key_prev_q, key_prev_d;
   logic [2:0]         edge_q, edge_d;
   mode_e              mode_q, mode_d;
   logic [2:0]         cursor_q, cursor_d;
   logic [N_ITEMS-1:0] item_active_q, item_active_d;
   logic [3:0]         screen_id_q, screen_id_d;

   always_comb begin
      key_d      = {key_back, key_sel, key_next};
      key_prev_d = key_q;
      edge_d     = key_q & ~key_prev_q;

      mode_d        = mode_q;
      cursor_d      = cursor_q;
      item_active_d = item_active_q;
      screen_id_d   = screen_id_q;

      case (mode_q)
         MODE_MENU: begin
            // select takes priority over a simultaneous next
            if (edge_q[K_SEL]) begin
               mode_d        = MODE_ACTIVE;
               item_active_d = N_ITEMS'(1) << cursor_q;
               screen_id_d   = 4'(N_ITEMS) + {1'b0, cursor_q};
            end else if (edge_q[K_NEXT]) begin
               cursor_d    = (cursor_q == 3'(N_ITEMS - 1)) ? 3'd0 : cursor_q + 3'd1;
               screen_id_d = {1'b0, cursor_d};
            end
         end
         MODE_ACTIVE: begin
            if (item_done || (edge_q[K_BACK] && !LOCK_MASK[cursor_q])) begin
               mode_d        = MODE_MENU;
               item_active_d = '0;
               screen_id_d   = {1'b0, cursor_q};
            end
         end
         default: mode_d = MODE_MENU;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q         <= '0;
         key_prev_q    <= '0;
         edge_q        <= '0;
         mode_q        <= MODE_MENU;
         cursor_q      <= '0;
         item_active_q <= '0;
         screen_id_q   <= '0;
      end else begin
         key_q         <= key_d;
         key_prev_q    <= key_prev_d;
         edge_q        <= edge_d;
         mode_q        <= mode_d;
         cursor_q      <= cursor_d;
         item_active_q <= item_active_d;
         screen_id_q   <= screen_id_d;
      end
   end

   assign screen_id   = screen_id_q;
   assign item_active = item_active_q;

   lcd_frame_streamer #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .REFRESH_CYCLES (REFRESH_CYCLES)
   ) u_streamer (
      .clk        (clk),
      .rst        (rst),
      .screen_id  (screen_id_q),
      .frame_data (frame_data),
      .frame_busy (frame_busy),
      .lcd        (lcd)
   );

endmodule
